float_copro_seq: RTL and testbench



---
 rtl/float_copro_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_float_copro_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/float_copro_seq.sv
// float_copro_seq
// ---------------------------------------------------------------------------
// Sequencing front-end of the LM32 floating-point coprocessor. The block takes
// one user-instruction request at a time. Add, sub and mul finish in a single
// execute cycle. Division runs as an iterative radix-2 restoring divider,
// followed by one normalise/round cycle. Each request returns its result on a
// one-cycle complete pulse.
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   user_valid      request strobe, held by the master until it sees complete
//   user_opcode     0 add, 1 sub, 2 mul, 3 div, anything else illegal (-> 0)
//   user_operand_0  op1, packed float in [FW-1:0]
//   user_operand_1  op2, packed float in [FW-1:0]
//   user_result     result float, zero-extended, held until next completion
//   user_complete   one-cycle pulse, user_result valid in that cycle
//   busy            high in every state except IDLE
// ---------------------------------------------------------------------------
module float_copro_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        user_valid,
   input  logic [10:0] user_opcode,
   input  logic [31:0] user_operand_0,
   input  logic [31:0] user_operand_1,
   output logic [31:0] user_result,
   output logic        user_complete,
   output logic        busy
);

   localparam int Nm = 23;
   localparam int Ne = 8;
   localparam int FW = 1 + Ne + Nm;
   localparam int CW = $clog2(Nm + 4);

   // Exponent arithmetic is done on Ne+2 bits; the MSB acts as a sign bit.
   localparam logic [Ne+1:0] BIAS  = (Ne+2)'(2**(Ne-1) - 1);
   localparam logic [Ne+1:0] E_ONE = (Ne+2)'(1);

   typedef enum logic [2:0] {IDLE, EXEC, DIV, NORM, DONE} state_t;

   state_t          state_reg;
   logic [10:0]     opcode_reg;
   logic [FW-1:0]   op1_reg;
   logic [FW-1:0]   op2_reg;
   logic [Nm+2:0]   rem_reg;
   logic [Nm+2:0]   quo_reg;
   logic [CW-1:0]   cnt_reg;
   logic [FW-1:0]   result_reg;
   logic            complete_reg;
   logic            busy_reg;

   logic [FW-1:0]   exec_result;
   logic [FW-1:0]   norm_result;
   logic [Nm+2:0]   div_b;
   logic [Nm+2:0]   rem_sub;
   logic            in_nz0;
   logic            in_nz1;

   // Final packing: underflow (exp <= 0) flushes to +0, overflow saturates
   // to a signed infinity.
   function automatic logic [FW-1:0] pack_float(input logic s,
                                                input logic [Ne+1:0] e,
                                                input logic [Nm-1:0] m);
      if (e[Ne+1] || e == '0)
         return '0;
      if (e[Ne:0] >= {1'b0, {Ne{1'b1}}})
         return {s, {Ne{1'b1}}, {Nm{1'b0}}};
      return {s, e[Ne-1:0], m};
   endfunction

   // Truncating multiply. A zero exponent field is treated as zero.
   function automatic logic [FW-1:0] float_mul(input logic [FW-1:0] a,
                                               input logic [FW-1:0] b);
      logic [2*Nm+1:0] p;
      logic [Ne+1:0]   e;
      logic [Nm-1:0]   m;
      if (a[FW-2:Nm] == '0 || b[FW-2:Nm] == '0)
         return '0;
      p = {{(Nm+1){1'b0}}, 1'b1, a[Nm-1:0]} * {{(Nm+1){1'b0}}, 1'b1, b[Nm-1:0]};
      e = {2'b00, a[FW-2:Nm]} + {2'b00, b[FW-2:Nm]} - BIAS;
      if (p[2*Nm+1]) begin
         m = p[2*Nm:Nm+1];
         e = e + E_ONE;
      end else begin
         m = p[2*Nm-1:Nm];
      end
      return pack_float(a[FW-1] ^ b[FW-1], e, m);
   endfunction

   // Truncating add. The larger magnitude sets the sign. The datapath keeps
   // a carry bit, the hidden bit and two guard bits below the mantissa.
   function automatic logic [FW-1:0] float_add(input logic [FW-1:0] a,
                                               input logic [FW-1:0] b);
      logic [FW-1:0] x;
      logic [FW-1:0] y;
      logic [Nm+3:0] mx;
      logic [Nm+3:0] my;
      logic [Nm+3:0] sm;
      logic [Ne-1:0] d;
      logic [Ne+1:0] e;
      if (a[FW-2:Nm] == '0)
         return b;
      if (b[FW-2:Nm] == '0)
         return a;
      if (a[FW-2:0] >= b[FW-2:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[FW-2:Nm] - y[FW-2:Nm];
      mx = {2'b01, x[Nm-1:0], 2'b00};
      my = {2'b01, y[Nm-1:0], 2'b00} >> d;
      sm = (x[FW-1] == y[FW-1]) ? mx + my : mx - my;
      if (sm == '0)
         return '0;
      e = {2'b00, x[FW-2:Nm]};
      if (sm[Nm+3]) begin
         sm = sm >> 1;
         e  = e + E_ONE;
      end else begin
         for (int i = 0; i < Nm + 3; i++) begin
            if (!sm[Nm+2]) begin
               sm = sm << 1;
               e  = e - E_ONE;
            end
         end
      end
      return pack_float(x[FW-1], e, sm[Nm+1:2]);
   endfunction

   function automatic logic [FW-1:0] float_sub(input logic [FW-1:0] a,
                                               input logic [FW-1:0] b);
      return float_add(a, {~b[FW-1], b[FW-2:0]});
   endfunction

   // Zero tests ignore the sign bit, so -0 also counts as zero.
   assign in_nz0  = |user_operand_0[FW-2:0];
   assign in_nz1  = |user_operand_1[FW-2:0];
   assign div_b   = {2'b01, op2_reg[Nm-1:0]};
   assign rem_sub = rem_reg - div_b;

   always_comb begin
      exec_result = '0;
      case (opcode_reg)
         11'd0: exec_result = float_add(op1_reg, op2_reg);
         11'd1: exec_result = float_sub(op1_reg, op2_reg);
         11'd2: exec_result = float_mul(op1_reg, op2_reg);
         11'd3: begin
            // EXEC only handles division when one of the operands is zero.
            if (op1_reg[FW-2:0] == '0)
               exec_result = '0;
            else
               exec_result = {op1_reg[FW-1] ^ op2_reg[FW-1], {Ne{1'b1}}, {Nm{1'b0}}};
         end
         default: exec_result = '0;
      endcase
   end

   always_comb begin
      logic [Ne+1:0] ne;
      logic [Nm-1:0] mant;
      logic [Nm:0]   mr;
      logic          rnd;
      ne = {2'b00, op1_reg[FW-2:Nm]} - {2'b00, op2_reg[FW-2:Nm]} + BIAS;
      // The quotient lies in [0.5, 2) scaled by 2^(Nm+2), so only one
      // normalising step is ever needed.
      if (quo_reg[Nm+2]) begin
         mant = quo_reg[Nm+1:2];
         rnd  = quo_reg[1];
      end else begin
         mant = quo_reg[Nm:1];
         rnd  = quo_reg[0];
         ne   = ne - E_ONE;
      end
      mr = {1'b0, mant} + {{Nm{1'b0}}, rnd};
      if (mr[Nm]) begin
         mant = '0;
         ne   = ne + E_ONE;
      end else begin
         mant = mr[Nm-1:0];
      end
      norm_result = pack_float(op1_reg[FW-1] ^ op2_reg[FW-1], ne, mant);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         opcode_reg   <= '0;
         op1_reg      <= '0;
         op2_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         cnt_reg      <= '0;
         result_reg   <= '0;
         complete_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         complete_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (user_valid) begin
                  opcode_reg <= user_opcode;
                  op1_reg    <= user_operand_0[FW-1:0];
                  op2_reg    <= user_operand_1[FW-1:0];
                  // Divider setup: R = {1,m1}, Q cleared, Nm+3 iterations.
                  rem_reg    <= {2'b01, user_operand_0[Nm-1:0]};
                  quo_reg    <= '0;
                  cnt_reg    <= CW'(Nm + 3);
                  busy_reg   <= 1'b1;
                  if (user_opcode == 11'd3 && in_nz0 && in_nz1)
                     state_reg <= DIV;
                  else
                     state_reg <= EXEC;
               end
            end
            EXEC: begin
               result_reg   <= exec_result;
               complete_reg <= 1'b1;
               state_reg    <= DONE;
            end
            DIV: begin
               if (rem_reg >= div_b) begin
                  rem_reg <= {rem_sub[Nm+1:0], 1'b0};
                  quo_reg <= {quo_reg[Nm+1:0], 1'b1};
               end else begin
                  rem_reg <= {rem_reg[Nm+1:0], 1'b0};
                  quo_reg <= {quo_reg[Nm+1:0], 1'b0};
               end
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1))
                  state_reg <= NORM;
            end
            NORM: begin
               result_reg   <= norm_result;
               complete_reg <= 1'b1;
               state_reg    <= DONE;
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign user_result   = 32'(result_reg);
   assign user_complete = complete_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_float_copro_seq.sv
// Directed testbench for float_copro_seq: arithmetic results, completion
// latency, busy timing, back-to-back requests, division special cases and
// reset in the middle of a division.
module tb_float_copro_seq;

   logic        clk;
   logic        reset_n;
   logic        user_valid;
   logic [10:0] user_opcode;
   logic [31:0] user_operand_0;
   logic [31:0] user_operand_1;
   logic [31:0] user_result;
   logic        user_complete;
   logic        busy;

   int errors;
   int checks;
   int cyc;
   int complete_cyc;
   int first_cyc;
   int pulses;

   float_copro_seq dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .user_valid     (user_valid),
      .user_opcode    (user_opcode),
      .user_operand_0 (user_operand_0),
      .user_operand_1 (user_operand_1),
      .user_result    (user_result),
      .user_complete  (user_complete),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to completion. Operands are scrambled
   // after capture to show that later changes are ignored.
   task automatic run_op(input string tag, input logic [10:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat);
      int lat;
      user_opcode    = op;
      user_operand_0 = a;
      user_operand_1 = b;
      user_valid     = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      user_opcode    = 11'd2;
      user_operand_0 = 32'hDEADBEEF;
      user_operand_1 = 32'h12345678;
      check({tag, "_busy_t1"}, 32'(busy), 32'd1);
      while (!user_complete && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      complete_cyc = cyc;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, user_result, exp_r);
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      $display("op %s: opcode=%0d a=%h b=%h result=%h latency=%0d", tag, op, a, b, user_result, lat);
      user_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_complete_low"}, 32'(user_complete), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      check({tag, "_result_held"}, user_result, exp_r);
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      reset_n        = 1'b0;
      user_valid     = 1'b0;
      user_opcode    = '0;
      user_operand_0 = '0;
      user_operand_1 = '0;
      #12;
      check("reset_result", user_result, 32'h0);
      check("reset_complete", 32'(user_complete), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul", 11'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 2);
      run_op("add", 11'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 2);
      first_cyc = complete_cyc;
      run_op("sub", 11'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 2);
      check("b2b_gap", 32'(complete_cyc - first_cyc), 32'd3);

      run_op("div_6_3", 11'd3, 32'h40C00000, 32'h40400000, 32'h40000000, 28);
      run_op("div_1_3", 11'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
      run_op("illegal", 11'd5, 32'h40400000, 32'h3F800000, 32'h00000000, 2);
      run_op("div_by0", 11'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 2);
      run_op("div_0by", 11'd3, 32'h00000000, 32'h40400000, 32'h00000000, 2);
      run_op("div_ovf", 11'd3, 32'h7F000000, 32'h00800000, 32'h7F800000, 28);

      // Reset in the middle of a division.
      user_opcode    = 11'd3;
      user_operand_0 = 32'h40C00000;
      user_operand_1 = 32'h40400000;
      user_valid     = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("mid_busy_before_rst", 32'(busy), 32'd1);
      reset_n    = 1'b0;
      user_valid = 1'b0;
      #1;
      check("rst_result", user_result, 32'h0);
      check("rst_complete", 32'(user_complete), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      $display("reset asserted mid-division: result=%h busy=%0d", user_result, busy);
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (user_complete) pulses++;
      end
      reset_n = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (user_complete) pulses++;
      end
      check("rst_no_complete", 32'(pulses), 32'd0);
      check("rst_idle_busy", 32'(busy), 32'd0);

      run_op("mul_after_rst", 11'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
